// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multi-cycle MIPS memory responder.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } mem_state_e;

  localparam logic [31:0] DEF_ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1001_0000;

  localparam logic RAM_SEL = 1'b1;
  localparam logic ROM_SEL = 1'b0;

  // An offset lies inside a window of 2^aw words when no bit above the word index is set.
  function automatic logic in_window(input logic [31:0] offset, input int unsigned aw);
    return ((offset >> (aw + 32'd2)) == 32'd0);
  endfunction

endpackage

// File: rtl/mips_mem_addr_check.sv
// Combinational legality check and byte-to-word translation of an incoming request.
module mips_mem_addr_check
  import mips_mem_pkg::*;
#(
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned RAM_AW   = 8,
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE
) (
  input  logic [31:0]       Address,
  input  logic              Ram_Rom,
  input  logic              read,
  input  logic              write,
  output logic              legal,
  output logic [ROM_AW-1:0] rom_idx,
  output logic [RAM_AW-1:0] ram_idx
);

  logic [31:0] rom_off_s;
  logic [31:0] ram_off_s;
  logic        in_range_s;

  assign rom_off_s = Address - ROM_BASE;
  assign ram_off_s = Address - RAM_BASE;
  assign rom_idx   = rom_off_s[ROM_AW+1:2];
  assign ram_idx   = ram_off_s[RAM_AW+1:2];

  // Range check against the selected window; addresses below a base wrap high and fail.
  always_comb begin
    in_range_s = 1'b0;
    if (Ram_Rom == RAM_SEL) begin
      in_range_s = in_window(ram_off_s, RAM_AW);
    end else begin
      in_range_s = in_window(rom_off_s, ROM_AW);
    end
    legal = (read ^ write) && (Address[1:0] == 2'b00) && in_range_s &&
            !(write && (Ram_Rom == ROM_SEL));
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Single-outstanding memory responder: wait-stated ROM/RAM access with MemReady/MemError completion.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned RAM_AW      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ROM_BASE    = DEF_ROM_BASE,
  parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  Ram_Rom,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemReady,
  output logic                  MemError,
  output logic                  Busy,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  mem_state_e            state_r;
  mem_state_e            state_next_s;
  logic [3:0]            wait_cnt_r;
  logic                  is_write_r;
  logic                  sel_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] read_data_r;
  logic [ROM_AW-1:0]     rom_addr_r;
  logic [RAM_AW-1:0]     ram_addr_r;
  logic                  mem_ready_r;
  logic                  mem_error_r;
  logic                  busy_r;
  logic                  req_s;
  logic                  legal_s;
  logic                  final_s;
  logic [ROM_AW-1:0]     rom_idx_s;
  logic [RAM_AW-1:0]     ram_idx_s;

  assign req_s   = MemRead | MemWrite;
  assign final_s = (state_r == ACCESS) && (wait_cnt_r == 4'd0);

  mips_mem_addr_check #(
    .ROM_AW   (ROM_AW),
    .RAM_AW   (RAM_AW),
    .ROM_BASE (ROM_BASE),
    .RAM_BASE (RAM_BASE)
  ) u_addr_check (
    .Address (Address),
    .Ram_Rom (Ram_Rom),
    .read    (MemRead),
    .write   (MemWrite),
    .legal   (legal_s),
    .rom_idx (rom_idx_s),
    .ram_idx (ram_idx_s)
  );

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next_s = legal_s ? ACCESS : ERR;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (wait_cnt_r == 4'd0) begin
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP:    state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State and completion flags; flags are registered from the next state so they align with RESP/ERR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      mem_ready_r <= 1'b0;
      mem_error_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      mem_ready_r <= (state_next_s == RESP) || (state_next_s == ERR);
      mem_error_r <= (state_next_s == ERR);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Request latches, wait counter and load-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r  <= 4'd0;
      is_write_r  <= 1'b0;
      sel_r       <= ROM_SEL;
      wdata_r     <= '0;
      read_data_r <= '0;
      rom_addr_r  <= '0;
      ram_addr_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            wait_cnt_r <= WAIT_LOAD;
            is_write_r <= MemWrite;
            sel_r      <= Ram_Rom;
            wdata_r    <= WriteData;
            // Word indices only move for legal accesses so they hold through error responses.
            if (legal_s && (Ram_Rom == RAM_SEL)) begin
              ram_addr_r <= ram_idx_s;
            end
            if (legal_s && (Ram_Rom == ROM_SEL)) begin
              rom_addr_r <= rom_idx_s;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end else if (!is_write_r) begin
            read_data_r <= (sel_r == RAM_SEL) ? ram_rdata : rom_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ram_we    = final_s && is_write_r && (sel_r == RAM_SEL);
  assign ram_wdata = wdata_r;
  assign ram_addr  = ram_addr_r;
  assign rom_addr  = rom_addr_r;
  assign ReadData  = read_data_r;
  assign MemReady  = mem_ready_r;
  assign MemError  = mem_error_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench: per-cycle model comparison on a WAIT_STATES=1 instance plus directed
// reset-abort (WAIT_STATES=3) and back-to-back (WAIT_STATES=0) scenarios.
`timescale 1ns/1ps
module tb_mips_mem_responder;

  localparam logic [31:0] ROMB = 32'h0040_0000;
  localparam logic [31:0] RAMB = 32'h1001_0000;
  localparam int W1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [7:0] i);
    logic [31:0] w;
    if (i == 8'd2) w = 32'h2008_0005;
    else w = 32'hC0DE_0000 | {24'h0, i};
    return w;
  endfunction

  // ---------------- instance 1: WAIT_STATES = 1 ----------------
  logic [31:0] a1, wd1, rdata1, ramwd1, romd1, ramrd1;
  logic rd1, wr1, sel1, rdy1, err1, busy1, we1;
  logic [7:0] roma1, rama1;
  logic [31:0] ram1 [256];

  assign romd1  = rom_word(roma1);
  assign ramrd1 = ram1[rama1];
  always @(posedge clk) if (we1) ram1[rama1] <= ramwd1;

  mips_mem_responder #(.WAIT_STATES(1)) u1 (
    .clk(clk), .reset(rst_n), .Address(a1), .WriteData(wd1), .MemRead(rd1), .MemWrite(wr1),
    .Ram_Rom(sel1), .ReadData(rdata1), .MemReady(rdy1), .MemError(err1), .Busy(busy1),
    .rom_addr(roma1), .rom_data(romd1), .ram_addr(rama1), .ram_wdata(ramwd1), .ram_we(we1),
    .ram_rdata(ramrd1));

  int we_cnt1 = 0;
  logic [7:0] we_addr1 = 8'd0;
  always @(negedge clk) if (we1) begin we_cnt1 <= we_cnt1 + 1; we_addr1 <= rama1; end

  // ---------------- instance 3: WAIT_STATES = 3 ----------------
  logic [31:0] a3, wd3, rdata3, ramwd3, romd3;
  logic rd3, wr3, sel3, rdy3, err3, busy3, we3;
  logic [7:0] roma3, rama3;
  assign romd3 = rom_word(roma3);

  mips_mem_responder #(.WAIT_STATES(3)) u3 (
    .clk(clk), .reset(rst_n), .Address(a3), .WriteData(wd3), .MemRead(rd3), .MemWrite(wr3),
    .Ram_Rom(sel3), .ReadData(rdata3), .MemReady(rdy3), .MemError(err3), .Busy(busy3),
    .rom_addr(roma3), .rom_data(romd3), .ram_addr(rama3), .ram_wdata(ramwd3), .ram_we(we3),
    .ram_rdata(32'h0));

  int we_cnt3 = 0;
  int rdy_cnt3 = 0;
  always @(posedge clk) if (we3) we_cnt3 <= we_cnt3 + 1;
  always @(negedge clk) if (rdy3) rdy_cnt3 <= rdy_cnt3 + 1;

  // ---------------- instance 0: WAIT_STATES = 0 ----------------
  logic [31:0] a0, wd0, rdata0, ramwd0, romd0;
  logic rd0, wr0, sel0, rdy0, err0, busy0, we0;
  logic [7:0] roma0, rama0;
  assign romd0 = rom_word(roma0);

  mips_mem_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst_n), .Address(a0), .WriteData(wd0), .MemRead(rd0), .MemWrite(wr0),
    .Ram_Rom(sel0), .ReadData(rdata0), .MemReady(rdy0), .MemError(err0), .Busy(busy0),
    .rom_addr(roma0), .rom_data(romd0), .ram_addr(rama0), .ram_wdata(ramwd0), .ram_we(we0),
    .ram_rdata(32'h0));

  // ---------------- behavioural model of instance 1 ----------------
  bit          chk_en = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_legal, m_rd, m_wr, m_sel;
  int          m_E, m_done;
  logic [31:0] m_idx, m_wdata, m_rval;
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] m_ram [256];

  // Per-cycle comparison of instance 1 against the model's timeline for the current request.
  always @(negedge clk) begin : cmp
    bit e_rdy, e_err, e_busy, e_we;
    if (chk_en) begin
      e_rdy  = m_valid && (cyc == m_done);
      e_err  = e_rdy && !m_legal;
      e_busy = m_valid && (cyc >= m_E) && (cyc <= m_done);
      e_we   = m_valid && m_legal && m_wr && (cyc == m_done - 1);
      if (e_rdy && m_legal && m_rd) exp_rdata = m_rval;
      chk("MemReady", {31'd0, rdy1}, {31'd0, e_rdy});
      chk("MemError", {31'd0, err1}, {31'd0, e_err});
      chk("Busy", {31'd0, busy1}, {31'd0, e_busy});
      chk("ram_we", {31'd0, we1}, {31'd0, e_we});
      chk("ReadData", rdata1, exp_rdata);
      if (e_we) begin
        chk("ram_addr", {24'd0, rama1}, m_idx);
        chk("ram_wdata", ramwd1, m_wdata);
      end
      if (e_busy && m_legal && m_rd && !m_sel) chk("rom_addr", {24'd0, roma1}, m_idx);
    end
  end

  // Issue one request on instance 1, update the model, hold until MemReady.
  task automatic req1(input bit rd, input bit wr, input bit sel, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat);
    logic [63:0] off;
    logic [31:0] base;
    @(negedge clk);
    rd1 = rd; wr1 = wr; sel1 = sel; a1 = addr; wd1 = wdata;
    base = sel ? RAMB : ROMB;
    off = ({32'd0, addr} + 64'h1_0000_0000 - {32'd0, base}) % 64'h1_0000_0000;
    m_idx   = off[33:2];
    m_legal = (rd != wr) && (addr % 4 == 0) && ((off / 4) < 256) && !(wr && !sel);
    m_rd = rd; m_wr = wr; m_sel = sel; m_wdata = wdata;
    m_E = cyc + 1;
    m_done = m_legal ? (m_E + W1 + 1) : m_E;
    if (m_legal && wr) m_ram[m_idx[7:0]] = wdata;
    if (m_legal && rd) m_rval = sel ? m_ram[m_idx[7:0]] : rom_word(m_idx[7:0]);
    m_valid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rdy1 && lat < 20);
    if (!rdy1) chk("req1_timeout", 32'd0, 32'd1);
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  logic [34:0] err_tab [6];
  int lat, n, base3, rbase3, wbase;

  initial begin
    for (int i = 0; i < 256; i++) begin ram1[i] = 32'h0; m_ram[i] = 32'h0; end
    a1 = 32'h0; wd1 = 32'h0; rd1 = 1'b0; wr1 = 1'b0; sel1 = 1'b0;
    a3 = 32'h0; wd3 = 32'h0; rd3 = 1'b0; wr3 = 1'b0; sel3 = 1'b0;
    a0 = 32'h0; wd0 = 32'h0; rd0 = 1'b0; wr0 = 1'b0; sel0 = 1'b0;
    err_tab[0] = {1'b0, 1'b1, 1'b0, 32'h0040_0000};  // store to ROM
    err_tab[1] = {1'b1, 1'b0, 1'b1, 32'h1001_0002};  // misaligned
    err_tab[2] = {1'b1, 1'b0, 1'b1, 32'h1001_0400};  // beyond RAM window
    err_tab[3] = {1'b1, 1'b0, 1'b1, 32'h0FFF_FFFC};  // below RAM base
    err_tab[4] = {1'b1, 1'b1, 1'b1, 32'h1001_0000};  // read and write together
    err_tab[5] = {1'b1, 1'b0, 1'b0, 32'h0040_0400};  // beyond ROM window

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ReadData", rdata1, 32'h0);
    chk("rst_MemReady", {31'd0, rdy1}, 32'd0);
    chk("rst_MemError", {31'd0, err1}, 32'd0);
    chk("rst_Busy", {31'd0, busy1}, 32'd0);
    chk("rst_ram_we", {31'd0, we1}, 32'd0);
    chk("rst_rom_addr", {24'd0, roma1}, 32'd0);
    chk("rst_ram_addr", {24'd0, rama1}, 32'd0);
    chk_en = 1'b1;

    req1(1'b1, 1'b0, 1'b0, 32'h0040_0008, 32'h0, lat);
    chk("rom_latency", lat, 32'd3);
    chk("rom_ReadData", rdata1, 32'h2008_0005);
    chk("rom_addr", {24'd0, roma1}, 32'd2);
    chk("rom_MemError", {31'd0, err1}, 32'd0);

    wbase = we_cnt1;
    req1(1'b0, 1'b1, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, lat);
    chk("wr_latency", lat, 32'd3);
    chk("wr_we_pulses", we_cnt1 - wbase, 32'd1);
    chk("wr_ram_addr", {24'd0, we_addr1}, 32'd4);
    req1(1'b1, 1'b0, 1'b1, 32'h1001_0010, 32'h0, lat);
    chk("rd_back", rdata1, 32'hDEAD_BEEF);

    for (int i = 0; i < 6; i++) begin
      wbase = we_cnt1;
      req1(err_tab[i][34], err_tab[i][33], err_tab[i][32], err_tab[i][31:0], 32'h5555_AAAA, lat);
      chk("err_latency", lat, 32'd1);
      chk("err_MemError", {31'd0, err1}, 32'd1);
      chk("err_no_we", we_cnt1 - wbase, 32'd0);
      chk("err_ReadData_held", rdata1, 32'hDEAD_BEEF);
    end

    req1(1'b0, 1'b1, 1'b1, 32'h1001_03FC, 32'h1234_5678, lat);
    req1(1'b1, 1'b0, 1'b1, 32'h1001_03FC, 32'h0, lat);
    chk("top_word_rd", rdata1, 32'h1234_5678);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    // Reset during the ACCESS phase of a WAIT_STATES=3 store.
    base3 = we_cnt3; rbase3 = rdy_cnt3;
    wr3 = 1'b1; sel3 = 1'b1; a3 = 32'h1001_0010; wd3 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy3}, 32'd1);
    chk("abort_ram_addr_pre", {24'd0, rama3}, 32'd4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ram_we", {31'd0, we3}, 32'd0);
    chk("abort_MemReady", {31'd0, rdy3}, 32'd0);
    chk("abort_MemError", {31'd0, err3}, 32'd0);
    chk("abort_Busy", {31'd0, busy3}, 32'd0);
    chk("abort_ReadData", rdata3, 32'h0);
    chk("abort_ram_addr", {24'd0, rama3}, 32'd0);
    wr3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_we_pulses", we_cnt3 - base3, 32'd0);
    chk("abort_ready_pulses", rdy_cnt3 - rbase3, 32'd0);
    chk("abort_idle", {31'd0, busy3}, 32'd0);

    // Normal WAIT_STATES=3 store after the abort.
    base3 = we_cnt3;
    wr3 = 1'b1; sel3 = 1'b1; a3 = 32'h1001_0020; wd3 = 32'h0BAD_CAFE;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy3 && n < 20);
    chk("ws3_latency", n, 32'd5);
    chk("ws3_we_pulses", we_cnt3 - base3, 32'd1);
    wr3 = 1'b0;

    // WAIT_STATES=0 back-to-back reads with the request held high.
    @(negedge clk);
    rd0 = 1'b1; sel0 = 1'b0; a0 = 32'h0040_0004;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy0 && n < 20);
    chk("b2b_first_latency", n, 32'd2);
    chk("b2b_first_data", rdata0, rom_word(8'd1));
    a0 = 32'h0040_000C;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy0 && n < 20);
    chk("b2b_period", n, 32'd3);
    chk("b2b_second_data", rdata0, rom_word(8'd3));
    rd0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the multi-cycle MIPS: it accepts the single-outstanding read/write requests that the control unit and datapath issue (address, write data, MemRead/MemWrite, Ram_Rom select) and completes each one with a MemReady handshake after a programmable number of wait states. It range-checks and aligns addresses, translates byte addresses to word indices, and drives the external ROM (instruction) and RAM (data) arrays. It flags illegal accesses with MemError instead of touching memory.

## Interface
- DATA_WIDTH, 32, data bus width
- ROM_AW, 8, ROM word-index width (ROM_AW ≤ 30)
- RAM_AW, 8, RAM word-index width (RAM_AW ≤ 30)
- WAIT_STATES, 1, extra ACCESS cycles per request (0..15)
- ROM_BASE, 32'h0040_0000, byte base of the ROM window
- RAM_BASE, 32'h1001_0000, byte base of the RAM window

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Address  in  32  byte address of request
- WriteData  in  DATA_WIDTH  store data
- MemRead  in  1  read request
- MemWrite  in  1  write request
- Ram_Rom  in  1  region select: 1 = RAM, 0 = ROM
- ReadData  out  DATA_WIDTH  registered load data
- MemReady  out  1  one-cycle completion strobe
- MemError  out  1  qualifies MemReady: request rejected
- Busy  out  1  high whenever state ≠ IDLE
- rom_addr  out  ROM_AW  ROM word index
- rom_data  in  DATA_WIDTH  ROM combinational read data
- ram_addr  out  RAM_AW  RAM word index
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_we  out  1  RAM write enable, one cycle per store
- ram_rdata  in  DATA_WIDTH  RAM combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE: if MemRead | MemWrite at a rising edge, latch Address, WriteData, Ram_Rom and direction. Load the wait counter with WAIT_STATES. Go to ACCESS if the request is legal, otherwise go to ERR.
- Legal request: exactly one of MemRead/MemWrite is set; Address[1:0] == 0; offset = Address − base is a 32-bit unsigned subtraction, so an address below the base wraps high; offset[31:2] < 2^AW for the selected region; and the request is not a write with Ram_Rom = 0.
- rom_addr / ram_addr = latched offset[AW+1:2]. Both hold their value outside ACCESS.
- ACCESS: the counter decrements each cycle. While the counter is 0 (final ACCESS cycle):
  - reads capture rom_data or ram_rdata into ReadData at the edge;
  - writes assert ram_we combinationally, with ram_wdata = latched WriteData.
  - Next state: RESP.
- RESP: MemReady = 1, MemError = 0 for one cycle, then IDLE.
- ERR: MemReady = 1, MemError = 1 for one cycle, then IDLE. ram_we stays 0 and ReadData is unchanged.
- ReadData holds its value until the next successful read completes.
- The requester holds the request until MemReady. Deasserting it after acceptance does not abort the access.
- A request still asserted in the RESP/ERR cycle is ignored. A new request is sampled only in IDLE, so back-to-back requests cost one IDLE cycle between them.

## Timing
- Reset values: state IDLE, ReadData 0, MemReady 0, MemError 0, Busy 0, ram_we 0, rom_addr 0, ram_addr 0, wait counter 0.
- Legal request sampled at edge E: ACCESS occupies cycles E+1 .. E+1+WAIT_STATES. MemReady is high in cycle E+2+WAIT_STATES. Latency = WAIT_STATES + 2 cycles.
- Illegal request: MemReady and MemError are high in cycle E+1. Latency is 1 cycle.
- ram_we is high in exactly one cycle, the final ACCESS cycle. The write is committed at the edge that ends that cycle.
- If reset asserts mid-ACCESS, ram_we drops immediately because the decode reads state, and no write is committed unless that edge has already passed. Outputs return to reset values with no MemReady.
- MemRead and MemWrite both high counts as illegal, with the 1-cycle error response.

## Structure
- Package mips_mem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, ERR);
  - default ROM_BASE / RAM_BASE constants;
  - region-select constants RAM_SEL = 1 and ROM_SEL = 0.
- Sub-module mips_mem_addr_check is purely combinational. Inputs: Address, Ram_Rom, read/write. Outputs: legal flag and word index. It is instantiated once on the IDLE-sampled inputs.
- The top level contains the FSM, wait counter, latches and ReadData register.

## Test plan
- ROM read, WAIT_STATES = 1, Address 32'h0040_0008, ROM word 2 = 32'h2008_0005 -> rom_addr = 2; MemReady high 3 cycles after the sampling edge; ReadData = 32'h2008_0005; MemError = 0.
- RAM write then read, Address 32'h1001_0010, WriteData 32'hDEAD_BEEF -> ram_we high for exactly one cycle with ram_addr = 4; the following read returns 32'hDEAD_BEEF.
- Error cases, each giving a 1-cycle MemReady + MemError with no ram_we and ReadData unchanged:
  - write with Ram_Rom = 0;
  - Address 32'h1001_0002 (misaligned);
  - Address 32'h1001_0400 with RAM_AW = 8 (out of range);
  - Address 32'h0FFF_FFFC with RAM selected (below the base, wraps).
- MemRead and MemWrite both high -> error response after 1 cycle.
- Reset asserted during ACCESS of a write with WAIT_STATES = 3 -> ram_we never pulses, MemReady never asserts, all outputs 0, state IDLE.
- WAIT_STATES = 0, back-to-back reads with the request held high -> MemReady every 3 cycles, and the second ReadData reflects the second address.
